// File: rtl/icache_fetch_arbiter_if.sv
// Request/response bundle between the IF-stage sources, the fetch arbiter and the I-Cache port.
// The master modport is the arbiter's view; slave is the surrounding environment's view.
interface icache_fetch_arbiter_if #(
    parameter int unsigned IDX_W     = 8,
    parameter int unsigned MAX_OUTST = 4
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;

    logic             dem_req_i;
    logic [IDX_W-1:0] dem_index_i;
    logic             dem_index_ok_o;
    logic             pf_req_i;
    logic [IDX_W-1:0] pf_index_i;
    logic             pf_index_ok_o;
    logic             flush_i;
    logic             inst_req_o;
    logic [IDX_W-1:0] inst_index_o;
    logic             inst_index_ok_i;
    logic             inst_data_ok_i;
    logic             rsp_valid_o;
    logic             rsp_owner_o;
    logic             rsp_kill_o;
    logic [CNT_W-1:0] outst_cnt_o;
    logic             proto_err_o;

    modport master (
        input  dem_req_i, dem_index_i, pf_req_i, pf_index_i, flush_i,
               inst_index_ok_i, inst_data_ok_i,
        output dem_index_ok_o, pf_index_ok_o, inst_req_o, inst_index_o,
               rsp_valid_o, rsp_owner_o, rsp_kill_o, outst_cnt_o, proto_err_o
    );

    modport slave (
        output dem_req_i, dem_index_i, pf_req_i, pf_index_i, flush_i,
               inst_index_ok_i, inst_data_ok_i,
        input  dem_index_ok_o, pf_index_ok_o, inst_req_o, inst_index_o,
               rsp_valid_o, rsp_owner_o, rsp_kill_o, outst_cnt_o, proto_err_o
    );
endinterface

// File: rtl/icache_fetch_arbiter.sv
// Arbitrates demand fetch vs. next-line prefetch onto the I-Cache index port and
// tracks in-flight requests in order so each response carries its owner and kill flag.
module icache_fetch_arbiter #(
    parameter int unsigned IDX_W       = 8,
    parameter int unsigned MAX_OUTST   = 4,
    parameter int unsigned STARVE_LIM  = 3,
    parameter bit          DRAIN_FLUSH = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    icache_fetch_arbiter_if.master bus
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;
    localparam int unsigned PTR_W = $clog2(MAX_OUTST);
    localparam int unsigned SW    = $clog2(STARVE_LIM + 1);

    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [MAX_OUTST-1:0] owner_q, owner_d, kill_q, kill_d;
    logic [SW-1:0]        starve_q, starve_d;
    logic                 proto_err_q, proto_err_d;
    logic                 en, sel_pf, req, grant, pop;

    // Issue gating and source selection; the handshake completes in the request cycle.
    always_comb begin
        en     = (state_q == RUN) && !bus.flush_i && (cnt_q < CNT_W'(MAX_OUTST));
        sel_pf = bus.pf_req_i && (!bus.dem_req_i || (starve_q == SW'(STARVE_LIM)));
        req    = en && (bus.dem_req_i || bus.pf_req_i);
        grant  = req && bus.inst_index_ok_i;
        pop    = bus.inst_data_ok_i && (cnt_q != '0);
    end

    assign bus.inst_req_o     = req;
    assign bus.inst_index_o   = sel_pf ? bus.pf_index_i : bus.dem_index_i;
    assign bus.dem_index_ok_o = grant && !sel_pf;
    assign bus.pf_index_ok_o  = grant && sel_pf;
    assign bus.rsp_valid_o    = pop;
    assign bus.rsp_owner_o    = pop && owner_q[rd_ptr_q];
    // A flush in the pop cycle still kills the head being returned.
    assign bus.rsp_kill_o     = pop && (kill_q[rd_ptr_q] || bus.flush_i);
    assign bus.outst_cnt_o    = cnt_q;
    assign bus.proto_err_o    = proto_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        owner_d     = owner_q;
        kill_d      = kill_q;
        starve_d    = starve_q;
        proto_err_d = proto_err_q;

        if (grant) begin
            owner_d[wr_ptr_q] = sel_pf;
            kill_d[wr_ptr_q]  = 1'b0;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(grant) - CNT_W'(pop);

        // Grant is blocked while flushing, so marking every slot cannot clobber a fresh push.
        if (bus.flush_i) begin
            kill_d = '1;
        end

        if (bus.flush_i || !bus.pf_req_i || bus.pf_index_ok_o) begin
            starve_d = '0;
        end else if (bus.dem_index_ok_o && (starve_q != SW'(STARVE_LIM))) begin
            starve_d = starve_q + SW'(1);
        end

        if (bus.inst_data_ok_i && (cnt_q == '0)) begin
            proto_err_d = 1'b1;
        end

        case (state_q)
            RUN: begin
                if (DRAIN_FLUSH && bus.flush_i && (cnt_d != '0)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_d == '0) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            owner_q     <= '0;
            kill_q      <= '0;
            starve_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            owner_q     <= owner_d;
            kill_q      <= kill_d;
            starve_q    <= starve_d;
            proto_err_q <= proto_err_d;
        end
    end
endmodule

// File: tb/tb_icache_fetch_arbiter.sv
// Directed bench for icache_fetch_arbiter: one instance without and one with post-flush draining.
module tb_icache_fetch_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    icache_fetch_arbiter_if #(.IDX_W(8), .MAX_OUTST(4)) bus0 ();
    icache_fetch_arbiter_if #(.IDX_W(8), .MAX_OUTST(4)) bus1 ();

    icache_fetch_arbiter #(.IDX_W(8), .MAX_OUTST(4), .STARVE_LIM(3), .DRAIN_FLUSH(1'b0))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    icache_fetch_arbiter #(.IDX_W(8), .MAX_OUTST(4), .STARVE_LIM(3), .DRAIN_FLUSH(1'b1))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus0.dem_req_i = 1'b0; bus0.dem_index_i = '0; bus0.pf_req_i = 1'b0; bus0.pf_index_i = '0;
        bus0.flush_i = 1'b0; bus0.inst_index_ok_i = 1'b0; bus0.inst_data_ok_i = 1'b0;
        bus1.dem_req_i = 1'b0; bus1.dem_index_i = '0; bus1.pf_req_i = 1'b0; bus1.pf_index_i = '0;
        bus1.flush_i = 1'b0; bus1.inst_index_ok_i = 1'b0; bus1.inst_data_ok_i = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #1;
        checks++; if (bus0.outst_cnt_o !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", bus0.outst_cnt_o); end
        checks++; if ({bus0.inst_req_o, bus0.dem_index_ok_o, bus0.pf_index_ok_o, bus0.rsp_valid_o, bus0.rsp_owner_o, bus0.rsp_kill_o, bus0.proto_err_o} !== 7'b0)
            begin errors++; $display("FAIL reset_outs: got nonzero outputs"); end
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    // Three demand grants then three in-order responses.
    task automatic test_demand();
        for (int i = 0; i < 3; i++) begin
            bus0.dem_req_i = 1'b1; bus0.dem_index_i = 8'h10 + 8'(i); bus0.inst_index_ok_i = 1'b1;
            #1;
            checks++; if (bus0.dem_index_ok_o !== 1'b1 || bus0.pf_index_ok_o !== 1'b0) begin errors++; $display("FAIL t1_grant[%0d]: got d%0b p%0b exp d1 p0", i, bus0.dem_index_ok_o, bus0.pf_index_ok_o); end
            checks++; if (bus0.inst_index_o !== 8'h10 + 8'(i)) begin errors++; $display("FAIL t1_index[%0d]: got %h exp %h", i, bus0.inst_index_o, 8'h10 + 8'(i)); end
            tick();
            checks++; if (bus0.outst_cnt_o !== 3'(i + 1)) begin errors++; $display("FAIL t1_cnt_up[%0d]: got %0d exp %0d", i, bus0.outst_cnt_o, i + 1); end
        end
        bus0.dem_req_i = 1'b0; bus0.inst_index_ok_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus0.inst_data_ok_i = 1'b1;
            #1;
            checks++; if ({bus0.rsp_valid_o, bus0.rsp_owner_o, bus0.rsp_kill_o} !== 3'b100) begin errors++; $display("FAIL t1_rsp[%0d]: got v/o/k %b exp 100", i, {bus0.rsp_valid_o, bus0.rsp_owner_o, bus0.rsp_kill_o}); end
            tick();
            checks++; if (bus0.outst_cnt_o !== 3'(2 - i)) begin errors++; $display("FAIL t1_cnt_dn[%0d]: got %0d exp %0d", i, bus0.outst_cnt_o, 2 - i); end
        end
        bus0.inst_data_ok_i = 1'b0;
    endtask

    // Both sources requesting: prefetch wins once after three lost cycles.
    task automatic test_starve();
        bit exp_pf;
        for (int c = 1; c <= 8; c++) begin
            exp_pf = (c == 4) || (c == 8);
            bus0.dem_req_i = 1'b1; bus0.dem_index_i = 8'hA0; bus0.pf_req_i = 1'b1; bus0.pf_index_i = 8'hB0;
            bus0.inst_index_ok_i = 1'b1; bus0.inst_data_ok_i = (c > 1);
            #1;
            checks++; if (bus0.pf_index_ok_o !== exp_pf || bus0.dem_index_ok_o !== !exp_pf) begin errors++; $display("FAIL t2_sel[%0d]: got p%0b d%0b exp p%0b", c, bus0.pf_index_ok_o, bus0.dem_index_ok_o, exp_pf); end
            checks++; if (bus0.inst_index_o !== (exp_pf ? 8'hB0 : 8'hA0)) begin errors++; $display("FAIL t2_index[%0d]: got %h", c, bus0.inst_index_o); end
            if (c > 1) begin
                checks++; if (bus0.rsp_owner_o !== (c == 5)) begin errors++; $display("FAIL t2_owner[%0d]: got %0b exp %0b", c, bus0.rsp_owner_o, c == 5); end
            end
            tick();
        end
        bus0.dem_req_i = 1'b0; bus0.pf_req_i = 1'b0; bus0.inst_index_ok_i = 1'b0; bus0.inst_data_ok_i = 1'b1;
        #1;
        checks++; if ({bus0.rsp_valid_o, bus0.rsp_owner_o} !== 2'b11) begin errors++; $display("FAIL t2_last_owner: got v/o %b exp 11", {bus0.rsp_valid_o, bus0.rsp_owner_o}); end
        tick();
        bus0.inst_data_ok_i = 1'b0;
        checks++; if (bus0.outst_cnt_o !== 3'd0) begin errors++; $display("FAIL t2_cnt: got %0d exp 0", bus0.outst_cnt_o); end
    endtask

    // Full FIFO blocks issue even when a response frees a slot that cycle.
    task automatic test_full();
        bus0.dem_req_i = 1'b1; bus0.inst_index_ok_i = 1'b1;
        repeat (4) tick();
        checks++; if (bus0.outst_cnt_o !== 3'd4) begin errors++; $display("FAIL t3_cnt_full: got %0d exp 4", bus0.outst_cnt_o); end
        checks++; if (bus0.inst_req_o !== 1'b0) begin errors++; $display("FAIL t3_req_full: got %0b exp 0", bus0.inst_req_o); end
        bus0.inst_data_ok_i = 1'b1;
        #1;
        checks++; if (bus0.inst_req_o !== 1'b0 || bus0.rsp_valid_o !== 1'b1) begin errors++; $display("FAIL t3_no_bypass: got req%0b v%0b exp req0 v1", bus0.inst_req_o, bus0.rsp_valid_o); end
        tick();
        bus0.inst_data_ok_i = 1'b0;
        checks++; if (bus0.outst_cnt_o !== 3'd3) begin errors++; $display("FAIL t3_cnt_pop: got %0d exp 3", bus0.outst_cnt_o); end
        #1;
        checks++; if (bus0.dem_index_ok_o !== 1'b1) begin errors++; $display("FAIL t3_regrant: got %0b exp 1", bus0.dem_index_ok_o); end
        tick();
        bus0.dem_req_i = 1'b0; bus0.inst_index_ok_i = 1'b0; bus0.inst_data_ok_i = 1'b1;
        repeat (4) tick();
        bus0.inst_data_ok_i = 1'b0;
        checks++; if (bus0.outst_cnt_o !== 3'd0) begin errors++; $display("FAIL t3_drain: got %0d exp 0", bus0.outst_cnt_o); end
    endtask

    // Flush coinciding with a response; issue resumes the following cycle.
    task automatic test_flush();
        bus0.dem_req_i = 1'b1; bus0.inst_index_ok_i = 1'b1;
        tick();
        bus0.dem_req_i = 1'b0; bus0.pf_req_i = 1'b1;
        tick();
        bus0.pf_req_i = 1'b0; bus0.dem_req_i = 1'b1; bus0.flush_i = 1'b1; bus0.inst_data_ok_i = 1'b1;
        #1;
        checks++; if (bus0.inst_req_o !== 1'b0 || bus0.dem_index_ok_o !== 1'b0) begin errors++; $display("FAIL t4_no_grant: got req%0b ok%0b exp 0 0", bus0.inst_req_o, bus0.dem_index_ok_o); end
        checks++; if ({bus0.rsp_valid_o, bus0.rsp_owner_o, bus0.rsp_kill_o} !== 3'b101) begin errors++; $display("FAIL t4_pop_kill: got v/o/k %b exp 101", {bus0.rsp_valid_o, bus0.rsp_owner_o, bus0.rsp_kill_o}); end
        tick();
        bus0.flush_i = 1'b0; bus0.inst_data_ok_i = 1'b0;
        checks++; if (bus0.outst_cnt_o !== 3'd1) begin errors++; $display("FAIL t4_cnt: got %0d exp 1", bus0.outst_cnt_o); end
        #1;
        checks++; if (bus0.dem_index_ok_o !== 1'b1) begin errors++; $display("FAIL t4_resume: got %0b exp 1", bus0.dem_index_ok_o); end
        tick();
        bus0.dem_req_i = 1'b0; bus0.inst_index_ok_i = 1'b0; bus0.inst_data_ok_i = 1'b1;
        #1;
        checks++; if ({bus0.rsp_valid_o, bus0.rsp_owner_o, bus0.rsp_kill_o} !== 3'b111) begin errors++; $display("FAIL t4_rem_kill: got v/o/k %b exp 111", {bus0.rsp_valid_o, bus0.rsp_owner_o, bus0.rsp_kill_o}); end
        tick();
        #1;
        checks++; if ({bus0.rsp_valid_o, bus0.rsp_owner_o, bus0.rsp_kill_o} !== 3'b100) begin errors++; $display("FAIL t4_new_live: got v/o/k %b exp 100", {bus0.rsp_valid_o, bus0.rsp_owner_o, bus0.rsp_kill_o}); end
        tick();
        bus0.inst_data_ok_i = 1'b0;
        checks++; if (bus0.outst_cnt_o !== 3'd0) begin errors++; $display("FAIL t4_cnt_end: got %0d exp 0", bus0.outst_cnt_o); end
    endtask

    // Drain-on-flush instance: issue held off until every killed response returns.
    task automatic test_drain();
        bus1.dem_req_i = 1'b1; bus1.inst_index_ok_i = 1'b1;
        repeat (2) tick();
        bus1.flush_i = 1'b1;
        #1;
        checks++; if (bus1.inst_req_o !== 1'b0) begin errors++; $display("FAIL t5_flush_req: got %0b exp 0", bus1.inst_req_o); end
        tick();
        bus1.flush_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus1.inst_data_ok_i = (i != 1);
            #1;
            checks++; if (bus1.inst_req_o !== 1'b0) begin errors++; $display("FAIL t5_hold[%0d]: got %0b exp 0", i, bus1.inst_req_o); end
            if (i != 1) begin
                checks++; if (bus1.rsp_kill_o !== 1'b1) begin errors++; $display("FAIL t5_kill[%0d]: got %0b exp 1", i, bus1.rsp_kill_o); end
            end
            tick();
        end
        bus1.inst_data_ok_i = 1'b0;
        checks++; if (bus1.outst_cnt_o !== 3'd0) begin errors++; $display("FAIL t5_cnt: got %0d exp 0", bus1.outst_cnt_o); end
        #1;
        checks++; if (bus1.dem_index_ok_o !== 1'b1) begin errors++; $display("FAIL t5_reissue: got %0b exp 1", bus1.dem_index_ok_o); end
        tick();
        bus1.dem_req_i = 1'b0; bus1.inst_index_ok_i = 1'b0; bus1.inst_data_ok_i = 1'b1;
        #1;
        checks++; if (bus1.rsp_kill_o !== 1'b0) begin errors++; $display("FAIL t5_live: got %0b exp 0", bus1.rsp_kill_o); end
        tick();
        bus1.inst_data_ok_i = 1'b0;
    endtask

    // Stray response sets a sticky error; index_ok without req pushes nothing; reset clears all.
    task automatic test_proto_reset();
        bus0.inst_index_ok_i = 1'b1;
        tick();
        bus0.inst_index_ok_i = 1'b0;
        checks++; if (bus0.outst_cnt_o !== 3'd0) begin errors++; $display("FAIL t6_ok_noreq: got %0d exp 0", bus0.outst_cnt_o); end
        bus0.inst_data_ok_i = 1'b1;
        #1;
        checks++; if (bus0.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL t6_stray_valid: got %0b exp 0", bus0.rsp_valid_o); end
        tick();
        bus0.inst_data_ok_i = 1'b0;
        checks++; if (bus0.proto_err_o !== 1'b1 || bus0.outst_cnt_o !== 3'd0) begin errors++; $display("FAIL t6_err_set: got err%0b cnt%0d exp 1 0", bus0.proto_err_o, bus0.outst_cnt_o); end
        bus0.dem_req_i = 1'b1; bus0.inst_index_ok_i = 1'b1;
        repeat (2) tick();
        checks++; if (bus0.proto_err_o !== 1'b1 || bus0.outst_cnt_o !== 3'd2) begin errors++; $display("FAIL t6_sticky: got err%0b cnt%0d exp 1 2", bus0.proto_err_o, bus0.outst_cnt_o); end
        idle();
        rst = 1'b1;
        #1;
        checks++; if (bus0.outst_cnt_o !== 3'd0 || bus0.proto_err_o !== 1'b0 || bus0.inst_req_o !== 1'b0) begin errors++; $display("FAIL t6_async_rst: got cnt%0d err%0b req%0b exp 0 0 0", bus0.outst_cnt_o, bus0.proto_err_o, bus0.inst_req_o); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bus0.outst_cnt_o !== 3'd0 || bus0.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL t6_post_rst: got cnt%0d v%0b exp 0 0", bus0.outst_cnt_o, bus0.rsp_valid_o); end
    endtask

    initial begin
        test_reset();
        test_demand();
        test_starve();
        test_full();
        test_flush();
        test_drain();
        test_proto_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
